// File: rtl/i2s_pkg.sv
// Shared types and default timing constants for the I2S clock generator.
package i2s_pkg;
   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   localparam int I2S_BITS_PER_CHANNEL = 32;
   localparam int I2S_BCLK_HALF_PERIOD = 4;
   localparam int I2S_MCLK_HALF_PERIOD = 4;
endpackage

// File: rtl/toggle_clock_divider.sv
// Registered toggle divider: the output flips every HALF_PERIOD cycles while
// i_run is high and is cleared synchronously when i_run drops.
module toggle_clock_divider
   import i2s_pkg::*;
#(
   parameter int HALF_PERIOD = 4
) (
   input  logic i_clock,
   input  logic i_reset,
   input  logic i_run,
   output logic o_clock,
   output logic o_falling_strobe
);
   localparam int CW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;

   if (HALF_PERIOD < 1) begin : g_bad_param
      $error("toggle_clock_divider: HALF_PERIOD must be >= 1");
   end

   logic [CW-1:0] count;
   logic          terminal;

   assign terminal = (count == CW'(HALF_PERIOD - 1));

   // High in the cycle before the edge that registers o_clock 1->0, so the
   // parent can update its own state on that same edge.
   assign o_falling_strobe = o_clock & terminal;

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         count   <= '0;
         o_clock <= 1'b0;
      end else if (!i_run) begin
         count   <= '0;
         o_clock <= 1'b0;
      end else if (terminal) begin
         count   <= '0;
         o_clock <= ~o_clock;
      end else begin
         count   <= count + 1'b1;
      end
   end
endmodule

// File: rtl/i2s_clock_generator.sv
// I2S MCLK/BCLK/LRCLK generator with frame-aligned start and stop.
// Optional MCLK divider enabled by defining I2S_CLKGEN_MCLK_EN.
module i2s_clock_generator
   import i2s_pkg::*;
#(
   parameter int MCLK_HALF_PERIOD = I2S_MCLK_HALF_PERIOD,
   parameter int BCLK_HALF_PERIOD = I2S_BCLK_HALF_PERIOD,
   parameter int BITS_PER_CHANNEL = I2S_BITS_PER_CHANNEL
) (
   input  logic i_clock,
   input  logic i_reset,
   input  logic i_enable,
   output logic o_codec_master_clock,
   output logic o_codec_bit_clock,
   output logic o_codec_lr_clock,
   output logic o_frame_start,
   output logic o_running
);
   localparam int BW = $clog2(BITS_PER_CHANNEL);

   if (MCLK_HALF_PERIOD < 1 || BCLK_HALF_PERIOD < 1 || BITS_PER_CHANNEL < 2) begin : g_bad_param
      $error("i2s_clock_generator: half periods must be >= 1 and BITS_PER_CHANNEL >= 2");
   end

   state_t        state;
   logic          running;
   logic          lr;
   logic          frame_start;
   logic [BW-1:0] bit_count;

   logic bclk_fall;
   logic lr_toggle;
   logic frame_end;
   logic stop;
   logic run_next;

   assign lr_toggle = bclk_fall && (bit_count == BW'(BITS_PER_CHANNEL - 1));
   assign frame_end = lr_toggle && lr;
   // Stop only where LR would return to left, so the codec never sees a partial frame.
   assign stop      = running && frame_end && !i_enable;
   assign run_next  = running && !stop;

   toggle_clock_divider #(.HALF_PERIOD(BCLK_HALF_PERIOD)) u_bclk (
      .i_clock          (i_clock),
      .i_reset          (i_reset),
      .i_run            (run_next),
      .o_clock          (o_codec_bit_clock),
      .o_falling_strobe (bclk_fall)
   );

`ifdef I2S_CLKGEN_MCLK_EN
   logic mclk_fall_unused;

   toggle_clock_divider #(.HALF_PERIOD(MCLK_HALF_PERIOD)) u_mclk (
      .i_clock          (i_clock),
      .i_reset          (i_reset),
      .i_run            (run_next),
      .o_clock          (o_codec_master_clock),
      .o_falling_strobe (mclk_fall_unused)
   );
`else
   assign o_codec_master_clock = 1'b0;
`endif

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         state       <= IDLE;
         running     <= 1'b0;
         lr          <= 1'b0;
         frame_start <= 1'b0;
         bit_count   <= '0;
      end else begin
         frame_start <= 1'b0;
         case (state)
            IDLE: begin
               lr        <= 1'b0;
               bit_count <= '0;
               if (i_enable) begin
                  state       <= RUN;
                  running     <= 1'b1;
                  frame_start <= 1'b1;
               end
            end
            RUN, DRAIN: begin
               if (stop) begin
                  state     <= IDLE;
                  running   <= 1'b0;
                  lr        <= 1'b0;
                  bit_count <= '0;
               end else begin
                  state <= i_enable ? RUN : DRAIN;
                  if (lr_toggle) begin
                     lr          <= ~lr;
                     bit_count   <= '0;
                     frame_start <= lr;
                  end else if (bclk_fall) begin
                     bit_count <= bit_count + 1'b1;
                  end
               end
            end
            default: begin
               state   <= IDLE;
               running <= 1'b0;
            end
         endcase
      end
   end

   assign o_codec_lr_clock = lr;
   assign o_frame_start    = frame_start;
   assign o_running        = running;
endmodule

// File: tb/tb_i2s_clock_generator.sv
// Bench for i2s_clock_generator: two configurations checked every cycle against
// an arithmetic frame-phase model, plus targeted timing checks.
module tb_i2s_clock_generator;
   localparam int BHA = 2, BA = 4,  MA = 1, FA = 2 * BA * 2 * BHA;
   localparam int BHB = 4, BB = 32, MB = 3, FB = 2 * BB * 2 * BHB;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic en  = 1'b0;
   int   tests = 0;
   int   fails = 0;
   int   cyc   = 0;

   logic mclk_a, bclk_a, lr_a, fs_a, run_a;
   logic mclk_b, bclk_b, lr_b, fs_b, run_b;
   logic [4:0] got_a, got_b, ea, eb;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   i2s_clock_generator #(.MCLK_HALF_PERIOD(MA), .BCLK_HALF_PERIOD(BHA), .BITS_PER_CHANNEL(BA)) dut_a (
      .i_clock(clk), .i_reset(rst), .i_enable(en),
      .o_codec_master_clock(mclk_a), .o_codec_bit_clock(bclk_a), .o_codec_lr_clock(lr_a),
      .o_frame_start(fs_a), .o_running(run_a));

   i2s_clock_generator #(.MCLK_HALF_PERIOD(MB), .BCLK_HALF_PERIOD(BHB), .BITS_PER_CHANNEL(BB)) dut_b (
      .i_clock(clk), .i_reset(rst), .i_enable(en),
      .o_codec_master_clock(mclk_b), .o_codec_bit_clock(bclk_b), .o_codec_lr_clock(lr_b),
      .o_frame_start(fs_b), .o_running(run_b));

   assign got_a = {run_a, fs_a, lr_a, bclk_a, mclk_a};
   assign got_b = {run_b, fs_b, lr_b, bclk_b, mclk_b};

   // Model: while running, every output is a function of the frame phase and of
   // the number of cycles since start; stop happens at a frame wrap with enable low.
   logic ma_run, mb_run;
   int   ma_ph, mb_ph, ma_ms, mb_ms;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         ma_run <= 1'b0; ma_ph <= 0; ma_ms <= 0;
      end else if (!ma_run) begin
         if (en) begin ma_run <= 1'b1; ma_ph <= 0; ma_ms <= 0; end
      end else if ((ma_ph + 1) % FA == 0 && !en) begin
         ma_run <= 1'b0; ma_ph <= 0; ma_ms <= 0;
      end else begin
         ma_ph <= (ma_ph + 1) % FA; ma_ms <= (ma_ms + 1) % (2 * MA);
      end
   end

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mb_run <= 1'b0; mb_ph <= 0; mb_ms <= 0;
      end else if (!mb_run) begin
         if (en) begin mb_run <= 1'b1; mb_ph <= 0; mb_ms <= 0; end
      end else if ((mb_ph + 1) % FB == 0 && !en) begin
         mb_run <= 1'b0; mb_ph <= 0; mb_ms <= 0;
      end else begin
         mb_ph <= (mb_ph + 1) % FB; mb_ms <= (mb_ms + 1) % (2 * MB);
      end
   end

   always_comb begin
      ea = '0;
      eb = '0;
      if (ma_run)
         ea = {1'b1, ma_ph == 0, ma_ph >= FA / 2, ((ma_ph / BHA) % 2) == 1,
`ifdef I2S_CLKGEN_MCLK_EN
               ((ma_ms / MA) % 2) == 1};
`else
               1'b0};
`endif
      if (mb_run)
         eb = {1'b1, mb_ph == 0, mb_ph >= FB / 2, ((mb_ph / BHB) % 2) == 1,
`ifdef I2S_CLKGEN_MCLK_EN
               ((mb_ms / MB) % 2) == 1};
`else
               1'b0};
`endif
   end

   task automatic test_reset();
      rst = 1'b1; en = 1'b0;
      repeat (3) begin
         @(negedge clk);
         tests++; if (got_a !== 5'b0) begin fails++; $display("FAIL reset_a got=%b exp=00000", got_a); end
         tests++; if (got_b !== 5'b0) begin fails++; $display("FAIL reset_b got=%b exp=00000", got_b); end
      end
   endtask

   task automatic test_start();
      int first_fs = -1, lr_rise = -1, second_fs = -1;
      logic lr_prev = 1'b0;
      rst = 1'b0;
      repeat (9) begin
         @(negedge clk);
         tests++; if (got_a !== 5'b0) begin fails++; $display("FAIL idle_a got=%b exp=00000", got_a); end
      end
      en = 1'b1;
      for (int i = 0; i < 120; i++) begin
         @(negedge clk);
         if (i == 0) begin
            tests++; if (fs_a !== 1'b1 || run_a !== 1'b1) begin fails++; $display("FAIL start_pulse fs=%b run=%b exp fs=1 run=1", fs_a, run_a); end
         end
         if (fs_a && first_fs >= 0 && second_fs < 0) second_fs = i;
         if (fs_a && first_fs < 0) first_fs = i;
         if (lr_a && !lr_prev && lr_rise < 0) lr_rise = i;
         lr_prev = lr_a;
         tests++; if (got_a !== ea) begin fails++; $display("FAIL start_a cyc=%0d got=%b exp=%b", cyc, got_a, ea); end
         tests++; if (got_b !== eb) begin fails++; $display("FAIL start_b cyc=%0d got=%b exp=%b", cyc, got_b, eb); end
      end
      tests++; if (lr_rise - first_fs !== 16) begin fails++; $display("FAIL lr_rise_offset got=%0d exp=16", lr_rise - first_fs); end
      tests++; if (second_fs - first_fs !== 32) begin fails++; $display("FAIL frame_spacing got=%0d exp=32", second_fs - first_fs); end
   endtask

   task automatic test_drain();
      repeat ($urandom_range(17, 30)) @(negedge clk);
      en = 1'b0;
      for (int i = 0; i < 560; i++) begin
         @(negedge clk);
         tests++; if (got_a !== ea) begin fails++; $display("FAIL drain_a cyc=%0d got=%b exp=%b", cyc, got_a, ea); end
         tests++; if (got_b !== eb) begin fails++; $display("FAIL drain_b cyc=%0d got=%b exp=%b", cyc, got_b, eb); end
      end
      tests++; if (got_a !== 5'b0 || got_b !== 5'b0) begin fails++; $display("FAIL drain_idle got_a=%b got_b=%b exp=00000", got_a, got_b); end
   endtask

   task automatic test_resume();
      int last_fs = -1;
      en = 1'b1;
      for (int i = 0; i < 200; i++) begin
         if (i == 70) en = 1'b0;
         if (i == 73) en = 1'b1;
         @(negedge clk);
         if (fs_a) begin
            if (last_fs >= 0) begin
               tests++; if (i - last_fs !== 32) begin fails++; $display("FAIL resume_spacing got=%0d exp=32", i - last_fs); end
            end
            last_fs = i;
         end
         tests++; if (got_a !== ea) begin fails++; $display("FAIL resume_a cyc=%0d got=%b exp=%b", cyc, got_a, ea); end
         tests++; if (got_b !== eb) begin fails++; $display("FAIL resume_b cyc=%0d got=%b exp=%b", cyc, got_b, eb); end
      end
   endtask

   task automatic test_reset_mid();
      en = 1'b1;
      repeat ($urandom_range(5, 25)) @(negedge clk);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      tests++; if (got_a !== 5'b0 || got_b !== 5'b0) begin fails++; $display("FAIL async_reset got_a=%b got_b=%b exp=00000", got_a, got_b); end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      tests++; if (fs_a !== 1'b1 || fs_b !== 1'b1) begin fails++; $display("FAIL restart_fs fs_a=%b fs_b=%b exp=1", fs_a, fs_b); end
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         tests++; if (got_a !== ea) begin fails++; $display("FAIL restart_a cyc=%0d got=%b exp=%b", cyc, got_a, ea); end
         tests++; if (got_b !== eb) begin fails++; $display("FAIL restart_b cyc=%0d got=%b exp=%b", cyc, got_b, eb); end
      end
   endtask

   task automatic test_random_enable();
      for (int i = 0; i < 3000; i++) begin
         en = (i < 400) ? ~en : 1'($urandom_range(0, 1));
         @(negedge clk);
         tests++; if (got_a !== ea) begin fails++; $display("FAIL rand_a cyc=%0d got=%b exp=%b", cyc, got_a, ea); end
         tests++; if (got_b !== eb) begin fails++; $display("FAIL rand_b cyc=%0d got=%b exp=%b", cyc, got_b, eb); end
      end
   endtask

   task automatic test_bclk_count();
      int   rises = 0;
      logic seen = 1'b0;
      logic bprev = 1'b0, lprev = 1'b0;
      en = 1'b0;
      repeat (FB + 8) @(negedge clk);
      tests++; if (run_b !== 1'b0) begin fails++; $display("FAIL pre_idle run_b=%b exp=0", run_b); end
      en = 1'b1;
      for (int i = 0; i < 10 * FB + 4; i++) begin
         if (i == 10 * FB - 40) en = 1'b0;
         @(negedge clk);
         if (fs_b) begin
            if (seen) begin
               tests++; if (rises !== 64) begin fails++; $display("FAIL bclk_per_lr got=%0d exp=64", rises); end
            end
            seen  = 1'b1;
            rises = 0;
         end
         if (bclk_b && !bprev) rises++;
         if (lr_b !== lprev) begin
            tests++; if (!(bprev && !bclk_b)) begin fails++; $display("FAIL lr_align bclk %b->%b exp 1->0", bprev, bclk_b); end
         end
         bprev = bclk_b;
         lprev = lr_b;
         tests++; if (got_b !== eb) begin fails++; $display("FAIL long_b cyc=%0d got=%b exp=%b", cyc, got_b, eb); end
      end
      tests++; if (got_b !== 5'b0) begin fails++; $display("FAIL long_stop got=%b exp=00000", got_b); end
   endtask

   initial begin
      test_reset();
      test_start();
      test_drain();
      test_resume();
      test_reset_mid();
      test_random_enable();
      test_bclk_count();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
